// File: rtl/alu_pkg.sv
// Shared constants for the add/sub datapath.
// Word width and the two saturation clamp values.
package alu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WORD_W-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice.
// Ports: a_i/b_i/cin_i in; s_o sum, cout_o, pg_o/gg_o group prop/gen.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o,
  output logic       pg_o,
  output logic       gg_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (&p[1:0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (&p[2:1] & g[0])
              | (&p[2:0] & c[0]);

  assign gg_o = g[3] | (p[3] & g[2])
              | (&p[3:2] & g[1])
              | (&p[3:1] & g[0]);
  assign pg_o = &p;
  assign c[4] = gg_o | (pg_o & c[0]);

  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

// File: rtl/addsub_16bit.sv
// Registered 16-bit saturating adder/subtractor.
// Ports: clk, rst (sync, high), A/B/Sub in; Sum/Ovf registered out.
module addsub_16bit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Sub,
  output logic [WORD_W-1:0] Sum,
  output logic              Ovf
);

  logic [WORD_W-1:0] bx;
  logic [WORD_W-1:0] r;
  logic [4:0]        c;
  logic [3:0]        pg;
  logic [3:0]        gg;
  logic [3:0]        cout_unused;
  logic              c14;
  logic              c15;
  logic              v;
  logic [WORD_W-1:0] sum_d;
  logic [WORD_W-1:0] sum_q;
  logic              ovf_d;
  logic              ovf_q;

  // Subtraction as A + ~B + 1; the +1 enters as carry-in.
  assign bx   = Sub ? ~B : B;
  assign c[0] = Sub;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    cla_4bit u_cla (
      .a_i   (A[4*i +: 4]),
      .b_i   (bx[4*i +: 4]),
      .cin_i (c[i]),
      .s_o   (r[4*i +: 4]),
      .cout_o(cout_unused[i]),
      .pg_o  (pg[i]),
      .gg_o  (gg[i])
    );
    assign c[i+1] = gg[i] | (pg[i] & c[i]);
  end

  // Carry into the sign bit recovered from its sum bit.
  assign c14 = r[15] ^ A[15] ^ bx[15];
  assign c15 = c[4];
  assign v   = c14 ^ c15;

  always_comb begin
    sum_d = r;
    ovf_d = v;
    if (v) begin
      sum_d = A[15] ? SAT_NEG : SAT_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign Sum = sum_q;
  assign Ovf = ovf_q;

endmodule

// File: tb/tb_addsub_16bit.sv
// Bench for addsub_16bit: vector table, corner
// sequences and a random regression via scoreboard.
module tb_addsub_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Sub;
  logic [15:0] Sum;
  logic        Ovf;

  int total;
  int bad;
  int cls [4];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  addsub_16bit dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .Sub(Sub),
    .Sum(Sum),
    .Ovf(Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact signed reference, then clamp.
  task automatic model(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        s,
    output logic [15:0] sum,
    output logic        ovf
  );
    int ia, ib, ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    ir = s ? ia - ib : ia + ib;
    ovf = 1'b0;
    if (ir > 32767) begin
      sum = 16'h7FFF;
      ovf = 1'b1;
    end else if (ir < -32768) begin
      sum = 16'h8000;
      ovf = 1'b1;
    end else begin
      sum = ir[15:0];
    end
  endtask

  task automatic step(
    input logic        r,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        s,
    input logic [15:0] es,
    input logic        eo,
    input string       nm
  );
    exp_t e;
    exp_t got;
    rst = r;
    A   = a;
    B   = b;
    Sub = s;
    e.sum = es;
    e.ovf = eo;
    e.nm  = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    total++;
    if (Sum !== got.sum || Ovf !== got.ovf) begin
      bad++;
      $display("FAIL %s: got Sum=%h Ovf=%b want Sum=%h Ovf=%b",
               got.nm, Sum, Ovf, got.sum, got.ovf);
    end
  endtask

  initial begin
    logic [15:0] ra, rb, es;
    logic        rs, eo;
    int          ia;
    total = 0;
    bad   = 0;
    foreach (cls[i]) cls[i] = 0;
    rst = 1'b1;
    A   = 16'h1234;
    B   = 16'h1111;
    Sub = 1'b0;

    tbl.push_back('{16'h0005, 16'hFFFD, 1'b0, 16'h0002, 1'b0});
    tbl.push_back('{16'h0005, 16'hFFFD, 1'b1, 16'h0008, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1});
    tbl.push_back('{16'h4000, 16'hC000, 1'b1, 16'h7FFF, 1'b1});
    tbl.push_back('{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1});
    tbl.push_back('{16'hC000, 16'h4001, 1'b1, 16'h8000, 1'b1});
    tbl.push_back('{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1});
    tbl.push_back('{16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1});
    tbl.push_back('{16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0});
    tbl.push_back('{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1});

    step(1'b1, 16'h1234, 16'h1111, 1'b0,
         16'h0000, 1'b0, "reset0");
    step(1'b1, 16'h1234, 16'h1111, 1'b0,
         16'h0000, 1'b0, "reset1");
    step(1'b0, 16'h1234, 16'h1111, 1'b0,
         16'h2345, 1'b0, "release");

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].a, tbl[i].b, tbl[i].sub,
           tbl[i].sum, tbl[i].ovf, $sformatf("vec%0d", i));
    end

    // Back-to-back: Ovf must toggle 1,0,1.
    step(1'b0, 16'h7FFF, 16'h0002, 1'b0,
         16'h7FFF, 1'b1, "b2b0");
    step(1'b0, 16'h0010, 16'h0003, 1'b1,
         16'h000D, 1'b0, "b2b1");
    step(1'b0, 16'h8001, 16'h0005, 1'b1,
         16'h8000, 1'b1, "b2b2");

    // Reset mid-stream drops the pending operands.
    step(1'b0, 16'h7FFF, 16'h0001, 1'b0,
         16'h7FFF, 1'b1, "pre_rst");
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0,
         16'h0000, 1'b0, "mid_rst");
    step(1'b1, 16'hxxxx, 16'hxxxx, 1'bx,
         16'h0000, 1'b0, "rst_x");
    step(1'b0, 16'h0100, 16'h0001, 1'b1,
         16'h00FF, 1'b0, "post_rst");

    for (int n = 0; n < 65535; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, es, eo);
      ia = int'($signed(ra));
      if (eo) begin
        if (!rs && ia >= 0) cls[0]++;
        else if (!rs) cls[1]++;
        else if (ia < 0) cls[2]++;
        else cls[3]++;
      end
      step(1'b0, ra, rb, rs, es, eo, "rand");
    end

    foreach (cls[i]) begin
      total++;
      if (cls[i] == 0) begin
        bad++;
        $display("FAIL cover%0d: hits=%0d want >0", i, cls[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_16bit.md
Name: addsub_16bit

Overview:
- Registered 16-bit two's-complement adder/subtractor with saturation on signed overflow.
- Serves as the ALU add/sub datapath: computes A+B or A−B and clamps the result to 0x7FFF / 0x8000 on overflow.
- Result and overflow flag are registered and valid one clock after the operands are sampled.

Parameters:
- None. Width is fixed at 16 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- A  input  16  signed operand A (two's complement)
- B  input  16  signed operand B (two's complement)
- Sub  input  1  0 = A+B, 1 = A−B
- Sum  output  16  registered saturated result
- Ovf  output  1  registered flag; 1 when the result for the sampled operands saturated

Behaviour:
- Reset: on a rising clk edge with rst=1, Sum <= 0x0000 and Ovf <= 0. rst has priority over new operands. Asserting rst mid-stream discards the pending result.
- Latency: exactly 1 cycle. A, B and Sub are sampled at edge N; Sum and Ovf reflect them after edge N. No handshake; a new operation is accepted every cycle.
- Effective operand: Bx = Sub ? ~B : B, with carry-in cin = Sub. The raw sum R = A + Bx + cin is modulo 2^16. Carry-out is ignored.
- Overflow: V = (A[15] == Bx[15]) && (R[15] != A[15]). Detection uses Bx, not −B, so B=0x8000 with Sub=1 is handled correctly.
- Saturation:
  - V && A[15]==0 → 0x7FFF (positive overflow)
  - V && A[15]==1 → 0x8000 (negative overflow)
  - otherwise → R
- Ovf <= V.
- Boundaries:
  - 0x7FFF+0x0001 → 0x7FFF, Ovf=1
  - 0x8000+0xFFFF → 0x8000, Ovf=1
  - 0x0000−0x8000 → 0x7FFF, Ovf=1
  - 0xFFFF−0x8000 → 0x7FFF, Ovf=0 (exact)
  - 0x8000−0x0001 → 0x8000, Ovf=1
  - Zero or mixed-sign addition never overflows.
- Arithmetic datapath: four cascaded 4-bit carry-lookahead slices.
  - Carry into bit 15 and carry out of bit 15 are also available.
  - V must equal c14 XOR c15; the implementation must be consistent with the sign rule above.
- No X propagation from inputs into state while rst=1.

Decomposition:
- Shared package alu_pkg: constants SAT_POS=16'h7FFF, SAT_NEG=16'h8000, WORD_W=16.
- Sub-module cla_4bit:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout, and group propagate/generate.
  - Instantiated four times with ripple between groups.
- Top level contains the B inversion, the overflow and saturation mux, and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with A=0x1234, B=0x1111 → Sum=0x0000, Ovf=0. Release rst → the next cycle Sum=0x2345.
- Normal add/sub: A=0x0005, B=0xFFFD, Sub=0 → Sum=0x0002. Same operands with Sub=1 → Sum=0x0008, Ovf=0. Result is valid one cycle after sampling.
- Positive saturation:
  - 0x7FFF+0x0001 → 0x7FFF, Ovf=1
  - 0x4000−0xC000 → 0x7FFF, Ovf=1
  - 0x0000−0x8000 → 0x7FFF, Ovf=1
- Negative saturation:
  - 0x8000+0x8000 → 0x8000, Ovf=1
  - 0xC000−0x4001 → 0x8000, Ovf=1
  - 0x8000−0x0001 → 0x8000, Ovf=1
- Back-to-back pipelining: apply an overflow case, a normal case and an overflow case in consecutive cycles → outputs follow in order, each one cycle late, with Ovf toggling 1, 0, 1.
- Random regression:
  - 65535 random (A, B, Sub) triples compared against a reference model that computes exactly in 17-bit signed arithmetic and clamps.
  - Must hit all four overflow classes: pos+pos, neg+neg, neg−pos, pos−neg.
